// File: rtl/imm_extend_pipe_pkg.sv
// Shared definitions for the immediate-extension datapath: mode encodings and default widths.
package imm_extend_pipe_pkg;

    localparam logic [1:0] IMM_MODE_SIGN   = 2'b00;
    localparam logic [1:0] IMM_MODE_ZERO   = 2'b01;
    localparam logic [1:0] IMM_MODE_UPPER  = 2'b10;
    localparam logic [1:0] IMM_MODE_BRANCH = 2'b11;

    localparam int IMM_IN_W_DEF  = 16;
    localparam int IMM_OUT_W_DEF = 32;

endpackage

// File: rtl/imm_ext_stage.sv
// One elastic register slice with valid/ready handshake; data only moves on a load.
module imm_ext_stage #(
    parameter int W = 34
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    assign in_ready  = !r_valid || out_ready;
    assign out_valid = r_valid;
    assign out_data  = r_data;

    // A load takes priority; otherwise a downstream take empties the slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (in_valid && in_ready) begin
            r_valid <= 1'b1;
            r_data  <= in_data;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined MIPS immediate extender (sign/zero/upper/branch) behind STAGES elastic slices.
// Optional macro IMM_EXTEND_BRANCH_EN enables the branch-offset shift for mode 11.
module imm_extend_pipe
    import imm_extend_pipe_pkg::*;
#(
    parameter int IN_W   = IMM_IN_W_DEF,
    parameter int OUT_W  = IMM_OUT_W_DEF,
    parameter int STAGES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [1:0]       out_mode
);

    logic [OUT_W-1:0] w_sext;
    logic [OUT_W-1:0] w_ext;
    logic [STAGES:0]  w_valid;
    logic [STAGES:0]  w_ready;
    logic [OUT_W+1:0] w_data [0:STAGES];

    assign w_sext = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};

    // Without the branch feature, mode 11 falls back to a plain sign-extend.
    always_comb begin
        w_ext = w_sext;
        case (in_mode)
            IMM_MODE_SIGN:   w_ext = w_sext;
            IMM_MODE_ZERO:   w_ext = {{(OUT_W-IN_W){1'b0}}, in_imm};
            IMM_MODE_UPPER:  w_ext = {in_imm, {(OUT_W-IN_W){1'b0}}};
            IMM_MODE_BRANCH: begin
`ifdef IMM_EXTEND_BRANCH_EN
                w_ext = {w_sext[OUT_W-3:0], 2'b00};
`else
                w_ext = w_sext;
`endif
            end
        endcase
    end

    assign w_valid[0]      = in_valid;
    assign w_data[0]       = {in_mode, w_ext};
    assign in_ready        = w_ready[0];
    assign w_ready[STAGES] = out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        imm_ext_stage #(
            .W(OUT_W + 2)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (w_valid[k]),
            .in_ready (w_ready[k]),
            .in_data  (w_data[k]),
            .out_valid(w_valid[k+1]),
            .out_ready(w_ready[k+1]),
            .out_data (w_data[k+1])
        );
    end

    assign out_valid = w_valid[STAGES];
    assign out_data  = w_data[STAGES][OUT_W-1:0];
    assign out_mode  = w_data[STAGES][OUT_W+1:OUT_W];

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Parametrised, pipelined immediate-extension unit for the MIPS datapath.
- Converts an IN_W-bit instruction immediate to an OUT_W-bit operand in one of four modes: sign-extend, zero-extend, upper-load (LUI), branch-offset.
- Wraps the conversion in STAGES elastic register stages with a valid/ready handshake, so decode can stall independently of execute.
- Sits between the instruction decoder and the ALU-operand mux.

Parameters:
- IN_W, 16, immediate input width; legal 2..OUT_W-3.
- OUT_W, 32, extended output width.
- STAGES, 1, number of elastic pipeline stages; legal 1..4; also the latency in cycles.

Ports:
- clk  in  1  rising-edge clock, sole clock domain.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream holds a valid immediate.
- in_ready  out  1  block can accept this cycle.
- in_imm  in  IN_W  raw immediate field.
- in_mode  in  2  00 sign, 01 zero, 10 upper, 11 branch.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  OUT_W  extended immediate.
- out_mode  out  2  mode that produced out_data, carried alongside it.

Behaviour:
- Reset: synchronous, active-low.
  - While rst_n=0 at a clk edge, every stage valid bit clears.
  - Reset values: out_valid=0, out_data=0, out_mode=00, in_ready=1 from the first cycle after reset.
  - Reset mid-operation discards all in-flight data with no output.
- Conversion (combinational, before stage 0), width rules:
  - 00 sign: replicate in_imm[IN_W-1] into bits OUT_W-1..IN_W.
  - 01 zero: upper OUT_W-IN_W bits are 0.
  - 10 upper: in_imm placed at bits OUT_W-1..OUT_W-IN_W, lower bits 0. If IN_W > OUT_W/2, the result is truncated to OUT_W.
  - 11 branch: sign-extend, then shift left by 2 (bits 1..0 = 0), keeping the low OUT_W bits.
- Transfers:
  - Input transfer: in_valid & in_ready at a clk edge.
  - Output transfer: out_valid & out_ready at a clk edge.
- Each stage is an elastic register: stage_ready = !stage_valid | next_ready. The last stage's next_ready is out_ready.
  - Stage k loads when the previous stage is valid and stage k is ready. Otherwise it holds.
  - Stage k clears valid when the next stage takes its data and nothing new arrives.
- Throughput and latency:
  - Full throughput: one transfer per cycle while out_ready=1.
  - Latency: an accepted input appears on out_data exactly STAGES cycles later if never stalled.
- Backpressure: while out_ready=0 with out_valid=1, out_data and out_mode hold stable. The pipeline fills, then in_ready drops.
  - Full: all STAGES valid and out_ready=0 gives in_ready=0.
  - Empty: out_valid=0, in_ready=1.
- Simultaneous in/out transfer on a full pipe is legal: all stages shift, occupancy stays unchanged, no bubble.
- Data registers update only on load, which saves power. Values in invalid stages are don't-care, except after reset, when they are 0.
- Ordering is strictly FIFO. No drop and no duplication.
- in_imm and in_mode are sampled only at the input transfer.

Optional Feature:
- Macro: IMM_EXTEND_BRANCH_EN.
- Defined: mode 11 performs the branch-offset conversion described above.
- Undefined: mode 11 behaves exactly as mode 00 (sign-extend, no shift), and out_mode still reports 11. The branch shift logic is not synthesised.

Decomposition:
- Shared package holds:
  - Mode encodings: IMM_MODE_SIGN=2'b00, IMM_MODE_ZERO=2'b01, IMM_MODE_UPPER=2'b10, IMM_MODE_BRANCH=2'b11.
  - Default IN_W/OUT_W constants used across the datapath.
- One sub-module is natural: imm_ext_stage, a single elastic register (valid, ready, data of width OUT_W+2). It is instantiated STAGES times in a generate loop.
- The conversion function stays inline in imm_extend_pipe.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> out_valid=0, out_data=0; in_ready=1 on the first cycle after release.
- Modes (STAGES=1, out_ready=1), in_imm=16'h8001:
  - mode 00 -> 32'hFFFF8001;
  - mode 01 -> 32'h00008001;
  - mode 10 -> 32'h80010000;
  - mode 11 -> 32'hFFFE0004, or 32'hFFFF8001 without IMM_EXTEND_BRANCH_EN.
- Latency/throughput (STAGES=3): stream 0x0001..0x0010 in mode 01 with out_ready=1 -> first output 3 cycles after the first accept, then one per cycle, in order, no gaps.
- Backpressure (STAGES=2): stream continuously with out_ready=0 -> in_ready falls after 2 accepts and out_data holds. Release out_ready -> all values emerge once, in order.
- Simultaneous transfer: full pipe, then assert in_valid and out_ready in the same cycle -> one value leaves, one enters, occupancy stays 2.
- Reset mid-stream: pulse rst_n=0 for 1 cycle with 3 items in flight -> none emerge; the next accepted item is the first output.
